edge_frame_align_ctrl: RTL and testbench
========================================

Name: edge_frame_align_ctrl

Overview:
Pixel-clock-domain controller that sequences the colorspace/Sobel datapath against the incoming video stream. It measures incoming frame geometry from I_VSYNC/I_DE, declares lock after consecutive well-formed frames, and gates the pipeline while locked. Each frame it issues a precisely delayed vertical-reset pulse so the video timing generator lines up with the datapath output (line-buffer plus pixel-pipeline latency). Geometry errors drop lock and are counted for debug.

Parameters:
HACT, 640, expected active pixels per line
VACT, 480, expected active lines per frame
VS_POL, 0, active level of I_VSYNC (0 = active-low, VGA 640x480)
LOCK_FRAMES, 2, consecutive good frames required to lock (>=1)
LINE_LATENCY, 1, datapath latency in whole lines
PIX_LATENCY, 4, additional datapath latency in pixel clocks (0..255)

Ports:
I_PCLK  in  1  pixel clock; sole clock
I_RST_N  in  1  asynchronous active-low reset
I_VSYNC  in  1  input vertical sync, synchronous to I_PCLK
I_DE  in  1  input data enable
I_ERR_CLR  in  1  synchronous clear of O_ERR_CNT
O_PIPE_EN  out  1  datapath enable; high only in LOCKED
O_VRST  out  1  one-cycle aligned vertical reset to timing generator
O_FRAME_START  out  1  one-cycle pulse on every detected frame start
O_LOCKED  out  1  state == LOCKED
O_COL  out  clog2(HACT)  column of current input pixel, valid while de_q high
O_ROW  out  clog2(VACT)  row of current input line
O_ERR_CNT  out  8  geometry error counter, saturating at 255

Behaviour:
- Reset (async, I_RST_N low): state IDLE; all outputs 0; all counters and flags 0. Reset mid-frame abandons everything; after release, behaviour is identical to power-up.
- Input stage: I_VSYNC and I_DE registered once (vs_q, de_q) plus one more stage for edge detection. An input sampled at edge n produces its event at edge n+1. frame_start = vs_q becomes active (== VS_POL) while the previous stage was inactive. de_rise / de_fall defined likewise.
- Pixel count: pix_cnt increments each de_q-high cycle and saturates at 2^(clog2(HACT)+1)-1. It clears on de_rise (first pixel = 0). O_COL = pix_cnt low bits.
- de_fall: line_bad = (pix_cnt_final != HACT). line_cnt increments and saturates. O_ROW = line_cnt at the current line.
- frame_start: frame_good = (line_cnt == VACT) and no line_bad since the previous frame_start. Then line_cnt and the bad flag clear, and O_FRAME_START pulses that cycle.
- Simultaneous de_fall and frame_start: the line check is applied first and counts toward the ending frame.
- FSM:
  - IDLE: first frame_start -> MEASURE with good_cnt = 0. That partial frame is not evaluated.
  - MEASURE: on frame_start, if frame_good then good_cnt++, else good_cnt = 0. When good_cnt reaches LOCK_FRAMES -> LOCKED, and the same frame_start arms alignment.
  - LOCKED: any line_bad or bad frame_start -> MEASURE with good_cnt = 0; O_ERR_CNT += 1; any armed alignment is cancelled.
- O_LOCKED and O_PIPE_EN are registered and go high the cycle after the transition into LOCKED. They drop the cycle after leaving LOCKED.
- Alignment: armed at every frame_start handled in LOCKED, including the frame_start that causes entry to LOCKED.
  - Count de_rise events in the frame, 0-based.
  - On de_rise of line index LINE_LATENCY, start a PIX_LATENCY down-counter.
  - O_VRST is high for exactly one cycle, PIX_LATENCY cycles after that de_rise. With PIX_LATENCY = 0 it is high in the de_rise cycle.
  - Exactly one O_VRST per locked frame. A new frame_start re-arms and cancels a pending count.
- O_ERR_CNT: I_ERR_CLR clears it first, then the same-cycle increment applies, giving a result of 1. Saturates at 255.

Decomposition:
- Shared package edge_det_pkg: VGA 640x480 geometry constants (HACT/VACT/porches), FSM state encoding (IDLE, MEASURE, LOCKED), counter width helpers.
- One natural sub-module, sync_edge_detect: registered input, rise/fall/active-level pulses. It is instantiated for VSYNC and DE.

Test Plan:
- HACT=8, VACT=4, LOCK_FRAMES=2: drive three clean frames -> O_FRAME_START x3; O_LOCKED rises one cycle after the 3rd frame_start (first frame_start only leaves IDLE); O_ERR_CNT = 0.
- Locked, LINE_LATENCY=1, PIX_LATENCY=4: O_VRST is a single-cycle pulse exactly 4 cycles after the registered DE rise of line 1. Repeat with PIX_LATENCY=0 -> pulse coincides with that de_rise cycle.
- Locked, inject a 7-pixel line -> O_LOCKED low the cycle after that de_fall; O_ERR_CNT = 1; no O_VRST later in that frame; relock after 2 further good frames.
- Frame with 5 lines while locked -> error at next frame_start, O_ERR_CNT increments. Assert I_ERR_CLR in the same cycle as an increment -> O_ERR_CNT = 1.
- Hold errors for 300 frames -> O_ERR_CNT saturates at 255.
- Assert I_RST_N low mid-line while locked -> all outputs 0 immediately, without a clock edge. After release, IDLE; relock requires a fresh first frame_start plus LOCK_FRAMES good frames.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared geometry constants, FSM encodings and width helpers for the
// frame-alignment controller and its input edge detectors.
package edge_det_pkg;

  // VGA 640x480 @ 60 Hz reference timing
  localparam int VGA_HACT = 640;
  localparam int VGA_HFP  = 16;
  localparam int VGA_HSW  = 96;
  localparam int VGA_HBP  = 48;
  localparam int VGA_VACT = 480;
  localparam int VGA_VFP  = 10;
  localparam int VGA_VSW  = 2;
  localparam int VGA_VBP  = 33;

  // Controller states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Width able to hold 0..max_val inclusive, with headroom to see one past it
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one input bit and flags when the registered copy enters or
// leaves its active level.
module sync_edge_detect #(
  parameter logic ACT_LVL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic act_o,
  output logic idle_o
);

  logic sample_q, sample_d;
  logic prev_q, prev_d;

  // Capture the input and keep one older copy for the edge compare
  always_comb begin
    sample_d = d_i;
    prev_d   = sample_q;
  end

  // Both history stages clear together so reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
    end
  end

  assign lvl_o  = sample_q;
  assign act_o  = (sample_q == ACT_LVL) && (prev_q != ACT_LVL);
  assign idle_o = (sample_q != ACT_LVL) && (prev_q == ACT_LVL);

endmodule

// File: rtl/edge_frame_align_ctrl.sv
// Measures incoming frame geometry, locks after consecutive good frames,
// gates the datapath while locked and emits a latency-aligned vertical reset.
module edge_frame_align_ctrl
  import edge_det_pkg::*;
#(
  parameter int HACT         = VGA_HACT,
  parameter int VACT         = VGA_VACT,
  parameter int VS_POL       = 0,
  parameter int LOCK_FRAMES  = 2,
  parameter int LINE_LATENCY = 1,
  parameter int PIX_LATENCY  = 4
) (
  input  logic                      I_PCLK,
  input  logic                      I_RST_N,
  input  logic                      I_VSYNC,
  input  logic                      I_DE,
  input  logic                      I_ERR_CLR,
  output logic                      O_PIPE_EN,
  output logic                      O_VRST,
  output logic                      O_FRAME_START,
  output logic                      O_LOCKED,
  output logic [$clog2(HACT)-1:0]   O_COL,
  output logic [$clog2(VACT)-1:0]   O_ROW,
  output logic [7:0]                O_ERR_CNT
);

  localparam int COL_W  = $clog2(HACT);
  localparam int ROW_W  = $clog2(VACT);
  localparam int PIX_W  = cnt_width(HACT);
  localparam int LINE_W = cnt_width(VACT);
  localparam int GOOD_W = cnt_width(LOCK_FRAMES);
  localparam int RISE_W = 8;
  localparam int DLY_W  = 8;

  logic vs_lvl, frame_start, vs_idle, vs_unused;
  logic de_lvl, de_rise, de_fall;

  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d, line_cnt_eff;
  logic              bad_q, bad_d, bad_eff;
  logic              line_bad, frame_good;

  logic [1:0]        state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d, good_inc;
  logic              locked_q, locked_d;
  logic              arm_set, err_evt;

  logic [RISE_W-1:0] rise_cnt_q, rise_cnt_d, rise_idx;
  logic              armed_q, armed_d, armed_eff, align_start;
  logic              pend_q, pend_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              vrst;

  logic [7:0]        err_cnt_q, err_cnt_d;

  sync_edge_detect #(.ACT_LVL(VS_POL != 0)) u_vs_det (
    .clk    (I_PCLK),
    .rst_n  (I_RST_N),
    .d_i    (I_VSYNC),
    .lvl_o  (vs_lvl),
    .act_o  (frame_start),
    .idle_o (vs_idle)
  );

  sync_edge_detect #(.ACT_LVL(1'b1)) u_de_det (
    .clk    (I_PCLK),
    .rst_n  (I_RST_N),
    .d_i    (I_DE),
    .lvl_o  (de_lvl),
    .act_o  (de_rise),
    .idle_o (de_fall)
  );

  // Only the start-of-vsync edge matters; the level and trailing edge are spare
  assign vs_unused = vs_lvl ^ vs_idle;

  // Pixel/line counting; the closing line is judged before the frame verdict
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (de_rise)
      pix_cnt_d = PIX_W'(1);
    else if (de_lvl && !(&pix_cnt_q))
      pix_cnt_d = pix_cnt_q + 1'b1;

    line_bad     = de_fall && (pix_cnt_q != PIX_W'(HACT));
    line_cnt_eff = line_cnt_q;
    if (de_fall && !(&line_cnt_q))
      line_cnt_eff = line_cnt_q + 1'b1;
    bad_eff    = bad_q | line_bad;
    frame_good = (line_cnt_eff == LINE_W'(VACT)) && !bad_eff;

    line_cnt_d = frame_start ? '0 : line_cnt_eff;
    bad_d      = frame_start ? 1'b0 : bad_eff;
  end

  // Lock FSM: IDLE waits for a frame boundary, MEASURE counts good frames,
  // LOCKED drops back on the first geometry error
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    good_inc   = good_cnt_q + 1'b1;
    arm_set    = 1'b0;
    err_evt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d    = ST_MEASURE;
          good_cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (frame_start) begin
          if (!frame_good) begin
            good_cnt_d = '0;
          end else if (good_inc == GOOD_W'(LOCK_FRAMES)) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
            arm_set    = 1'b1;
          end else begin
            good_cnt_d = good_inc;
          end
        end
      end
      ST_LOCKED: begin
        if (line_bad || (frame_start && !frame_good)) begin
          state_d    = ST_MEASURE;
          good_cnt_d = '0;
          err_evt    = 1'b1;
        end else if (frame_start) begin
          arm_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  // Vertical-reset alignment: count DE rises per frame and fire once, a fixed
  // pixel delay after the rise of the line matching the datapath line latency
  always_comb begin
    rise_idx  = frame_start ? '0 : rise_cnt_q;
    armed_eff = armed_q;
    if (frame_start)
      armed_eff = arm_set;
    if (err_evt)
      armed_eff = 1'b0;
    align_start = armed_eff && de_rise && (rise_idx == RISE_W'(LINE_LATENCY));

    rise_cnt_d = rise_idx;
    if (de_rise && !(&rise_idx))
      rise_cnt_d = rise_idx + 1'b1;
    armed_d = armed_eff && !align_start;

    vrst  = (pend_q && (dly_q == DLY_W'(1))) || (align_start && (PIX_LATENCY == 0));
    pend_d = pend_q;
    dly_d  = dly_q;
    if (pend_q) begin
      if (dly_q == DLY_W'(1))
        pend_d = 1'b0;
      else
        dly_d = dly_q - 1'b1;
    end
    if (frame_start || err_evt)
      pend_d = 1'b0;
    if (align_start && (PIX_LATENCY != 0)) begin
      pend_d = 1'b1;
      dly_d  = DLY_W'(PIX_LATENCY);
    end
  end

  // Debug error counter: clear wins first, then a same-cycle error still counts
  always_comb begin
    err_cnt_d = I_ERR_CLR ? 8'd0 : err_cnt_q;
    if (err_evt && !(&err_cnt_d))
      err_cnt_d = err_cnt_d + 8'd1;
  end

  // All controller state, cleared asynchronously
  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      bad_q      <= 1'b0;
      state_q    <= ST_IDLE;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      rise_cnt_q <= '0;
      armed_q    <= 1'b0;
      pend_q     <= 1'b0;
      dly_q      <= '0;
      err_cnt_q  <= 8'd0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      bad_q      <= bad_d;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      rise_cnt_q <= rise_cnt_d;
      armed_q    <= armed_d;
      pend_q     <= pend_d;
      dly_q      <= dly_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign O_PIPE_EN     = locked_q;
  assign O_LOCKED      = locked_q;
  assign O_VRST        = vrst;
  assign O_FRAME_START = frame_start;
  assign O_COL         = de_rise ? '0 : pix_cnt_q[COL_W-1:0];
  assign O_ROW         = line_cnt_q[ROW_W-1:0];
  assign O_ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_edge_frame_align_ctrl.sv
// Directed bench for edge_frame_align_ctrl: 8x4 geometry, two lock frames,
// one instance with a 4-pixel delay and one with zero delay.
module tb_edge_frame_align_ctrl;

  localparam int HACT = 8;
  localparam int VACT = 4;

  typedef struct {
    int nlines;
    int badline;
    int badlen;
    int exp_locked;
    int exp_err;
    int exp_vrst;
  } frame_vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       de = 1'b0;
  logic       err_clr = 1'b0;

  logic       pipe_en, vrst, fstart, locked;
  logic [2:0] col;
  logic [1:0] row;
  logic [7:0] err_cnt;
  logic       pipe_en0, vrst0, fstart0, locked0;
  logic [2:0] col0;
  logic [1:0] row0;
  logic [7:0] err_cnt0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int vrst_n = 0, vrst0_n = 0, fs_n = 0, fs0_n = 0;
  int vrst_cyc = 0, vrst0_cyc = 0;
  int line1_cyc = 0;

  frame_vec_t vecs[12];

  edge_frame_align_ctrl #(
    .HACT(HACT), .VACT(VACT), .VS_POL(0), .LOCK_FRAMES(2),
    .LINE_LATENCY(1), .PIX_LATENCY(4)
  ) dut (
    .I_PCLK(clk), .I_RST_N(rst_n), .I_VSYNC(vsync), .I_DE(de),
    .I_ERR_CLR(err_clr), .O_PIPE_EN(pipe_en), .O_VRST(vrst),
    .O_FRAME_START(fstart), .O_LOCKED(locked), .O_COL(col),
    .O_ROW(row), .O_ERR_CNT(err_cnt)
  );

  edge_frame_align_ctrl #(
    .HACT(HACT), .VACT(VACT), .VS_POL(0), .LOCK_FRAMES(2),
    .LINE_LATENCY(1), .PIX_LATENCY(0)
  ) dut0 (
    .I_PCLK(clk), .I_RST_N(rst_n), .I_VSYNC(vsync), .I_DE(de),
    .I_ERR_CLR(err_clr), .O_PIPE_EN(pipe_en0), .O_VRST(vrst0),
    .O_FRAME_START(fstart0), .O_LOCKED(locked0), .O_COL(col0),
    .O_ROW(row0), .O_ERR_CNT(err_cnt0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count single-cycle pulses mid-cycle and remember when the last one landed
  always @(negedge clk) begin
    if (vrst)    begin vrst_n  = vrst_n + 1;  vrst_cyc  = cyc; end
    if (vrst0)   begin vrst0_n = vrst0_n + 1; vrst0_cyc = cyc; end
    if (fstart)  fs_n  = fs_n + 1;
    if (fstart0) fs0_n = fs0_n + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared = compared + 1;
    if (actual != expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveVsync();
    vsync = 1'b0;
    tick();
    tick();
    vsync = 1'b1;
    tick();
    tick();
  endtask

  task automatic driveLine(input int len, input int lidx, input bit chk);
    for (int j = 0; j < len; j++) begin
      de = 1'b1;
      if (lidx == 1 && j == 0) line1_cyc = cyc;
      tick();
      if (chk) begin
        checkOutput($sformatf("col l%0d p%0d", lidx, j), int'(col), j);
        checkOutput($sformatf("row l%0d p%0d", lidx, j), int'(row), lidx);
        checkOutput($sformatf("col0 l%0d p%0d", lidx, j), int'(col0), j);
        checkOutput($sformatf("row0 l%0d p%0d", lidx, j), int'(row0), lidx);
      end
    end
    de = 1'b0;
    tick();
    tick();
  endtask

  task automatic applyStimulus(input int nlines, input int badline, input int badlen,
                               input int chkrow);
    driveVsync();
    for (int l = 0; l < nlines; l++)
      driveLine((l == badline) ? badlen : HACT, l, (l == chkrow));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " locked"}, int'(locked), 0);
    checkOutput({tag, " pipe_en"}, int'(pipe_en), 0);
    checkOutput({tag, " vrst"}, int'(vrst), 0);
    checkOutput({tag, " fstart"}, int'(fstart), 0);
    checkOutput({tag, " col"}, int'(col), 0);
    checkOutput({tag, " row"}, int'(row), 0);
    checkOutput({tag, " err"}, int'(err_cnt), 0);
    checkOutput({tag, " err0"}, int'(err_cnt0), 0);
  endtask

  initial begin
    int v0, vz0, f0, fz0;

    // nlines, badline, badlen, locked after, err after, vrst pulses in frame
    vecs[0]  = '{4, -1, 0, 0, 0, 0};
    vecs[1]  = '{4, -1, 0, 0, 0, 0};
    vecs[2]  = '{4, -1, 0, 1, 0, 1};
    vecs[3]  = '{4, -1, 0, 1, 0, 1};
    vecs[4]  = '{4,  0, 7, 0, 1, 0};
    vecs[5]  = '{4, -1, 0, 0, 1, 0};
    vecs[6]  = '{4, -1, 0, 0, 1, 0};
    vecs[7]  = '{4, -1, 0, 1, 1, 1};
    vecs[8]  = '{5, -1, 0, 1, 1, 1};
    vecs[9]  = '{4, -1, 0, 0, 2, 0};
    vecs[10] = '{4, -1, 0, 0, 2, 0};
    vecs[11] = '{4, -1, 0, 1, 2, 1};

    repeat (3) tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 12; i++) begin
      v0  = vrst_n;
      vz0 = vrst0_n;
      f0  = fs_n;
      fz0 = fs0_n;
      applyStimulus(vecs[i].nlines, vecs[i].badline, vecs[i].badlen, -1);
      checkOutput($sformatf("v%0d locked", i), int'(locked), vecs[i].exp_locked);
      checkOutput($sformatf("v%0d pipe_en", i), int'(pipe_en), vecs[i].exp_locked);
      checkOutput($sformatf("v%0d locked0", i), int'(locked0), vecs[i].exp_locked);
      checkOutput($sformatf("v%0d pipe_en0", i), int'(pipe_en0), vecs[i].exp_locked);
      checkOutput($sformatf("v%0d err", i), int'(err_cnt), vecs[i].exp_err);
      checkOutput($sformatf("v%0d err0", i), int'(err_cnt0), vecs[i].exp_err);
      checkOutput($sformatf("v%0d vrst", i), vrst_n - v0, vecs[i].exp_vrst);
      checkOutput($sformatf("v%0d vrst0", i), vrst0_n - vz0, vecs[i].exp_vrst);
      checkOutput($sformatf("v%0d fstart", i), fs_n - f0, 1);
      checkOutput($sformatf("v%0d fstart0", i), fs0_n - fz0, 1);
    end

    // Error-clear collides with a short-line error while locked
    v0 = vrst_n;
    driveVsync();
    for (int j = 0; j < 7; j++) begin
      de = 1'b1;
      tick();
    end
    de = 1'b0;
    tick();
    checkOutput("clr locked still high", int'(locked), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("clr locked dropped", int'(locked), 0);
    checkOutput("clr err", int'(err_cnt), 1);
    for (int l = 1; l < VACT; l++) driveLine(HACT, l, 1'b0);
    checkOutput("clr no vrst", vrst_n - v0, 0);

    // Relock needs the bad frame to close plus two good frames
    for (int k = 0; k < 3; k++) begin
      applyStimulus(VACT, -1, 0, -1);
      checkOutput($sformatf("relock %0d", k), int'(locked), (k == 2) ? 1 : 0);
    end

    // Locked frame: exact vrst placement and column/row tracking on line 2
    v0  = vrst_n;
    vz0 = vrst0_n;
    applyStimulus(VACT, -1, 0, 2);
    checkOutput("align vrst count", vrst_n - v0, 1);
    checkOutput("align vrst0 count", vrst0_n - vz0, 1);
    checkOutput("align delay p4", vrst_cyc - line1_cyc, 5);
    checkOutput("align delay p0", vrst0_cyc - line1_cyc, 1);

    // Repeated lock/error episodes drive the counter into saturation
    for (int e = 0; e < 260; e++) begin
      applyStimulus(1, 0, 7, -1);
      for (int k = 0; k < 3; k++) applyStimulus(VACT, -1, 0, -1);
      if (e == 99) checkOutput("sat mid err", int'(err_cnt), 101);
    end
    checkOutput("sat err", int'(err_cnt), 255);
    checkOutput("sat err0", int'(err_cnt0), 255);
    checkOutput("sat locked", int'(locked), 1);

    // Asynchronous reset mid-line while locked
    driveVsync();
    de = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("pre-rst col", int'(col), 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async rst");
    de = 1'b0;
    vsync = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(VACT, -1, 0, -1);
      checkOutput($sformatf("post-rst lock %0d", k), int'(locked), (k == 2) ? 1 : 0);
    end
    checkOutput("post-rst err", int'(err_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
